// File: rtl/hdmi_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_clk_rst_seq
// Purpose  : Power-up / relock sequencer for the HDMI TX clock tree
//            (rPLL 5x serial clock -> CLKDIV /5 pixel clock -> OSER10).
//            Holds the PLL in reset and then qualifies lock. After that it
//            releases CLKDIV, then the serializers, then the pixel-domain
//            logic. Any lock loss, lock timeout or soft restart sends the
//            whole tree back to PLL reset.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   reference clock (free-running crystal domain)
//   resetn        in   synchronous active-low reset
//   pll_lock      in   rPLL LOCK, asynchronous (2-flop synchronised here)
//   restart       in   single-cycle soft restart request
//   pll_reset     out  rPLL RESET, active-high
//   clkdiv_resetn out  CLKDIV RESETN, active-low
//   oser_reset    out  OSER10 RESET, active-high
//   video_resetn  out  pixel-domain reset, active-low
//   ready         out  clock tree up (high only in RUN)
//   timeout_cnt   out  lock-timeout events, saturating at 255
//   relock_cnt    out  lock-loss events after qualification, saturating
// ============================================================================
module hdmi_clk_rst_seq #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int DIV_SETTLE_CYCLES  = 16,
  parameter int SER_SETTLE_CYCLES  = 16,
  parameter int CNT_W              = 17
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       clkdiv_resetn,
  output logic       oser_reset,
  output logic       video_resetn,
  output logic       ready,
  output logic [7:0] timeout_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    ST_PLL_RST     = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_STABLE = 3'd2,
    ST_DIV_RELEASE = 3'd3,
    ST_SER_RELEASE = 3'd4,
    ST_RUN         = 3'd5
  } state_t;

  // Terminal counts: a timed state of N cycles leaves at count N-1.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(DIV_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SER_LAST     = CNT_W'(SER_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] phase_cnt, phase_next;
  logic [CNT_W-1:0] tmo_cnt, tmo_next;
  logic [7:0]       timeout_next, relock_next;
  logic             lock_meta, lock_s;
  logic             phase_run;
  logic [4:0]       outs_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // --------------------------------------------------------------------------
  // State / counters / registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_PLL_RST;
      phase_cnt     <= '0;
      tmo_cnt       <= '0;
      timeout_cnt   <= 8'd0;
      relock_cnt    <= 8'd0;
      lock_meta     <= 1'b0;
      lock_s        <= 1'b0;
      pll_reset     <= 1'b1;
      clkdiv_resetn <= 1'b0;
      oser_reset    <= 1'b1;
      video_resetn  <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= state_next;
      phase_cnt     <= phase_next;
      tmo_cnt       <= tmo_next;
      timeout_cnt   <= timeout_next;
      relock_cnt    <= relock_next;
      lock_meta     <= pll_lock;
      lock_s        <= lock_meta;
      {pll_reset, clkdiv_resetn, oser_reset, video_resetn, ready} <= outs_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, counter and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    tmo_next     = tmo_cnt;
    timeout_next = timeout_cnt;
    relock_next  = relock_cnt;
    phase_run    = 1'b0;

    case (state)
      ST_PLL_RST: begin
        phase_run = 1'b1;
        tmo_next  = '0;
        if (phase_cnt == PLL_RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (tmo_cnt == TIMEOUT_LAST) begin
          state_next   = ST_PLL_RST;
          timeout_next = sat_inc(timeout_cnt);
        end else begin
          tmo_next = tmo_cnt + CNT_ONE;
          if (lock_s) state_next = ST_LOCK_STABLE;
        end
      end
      ST_LOCK_STABLE: begin
        phase_run = 1'b1;
        // Timeout wins over a stable-exit landing on the same cycle.
        if (tmo_cnt == TIMEOUT_LAST) begin
          state_next   = ST_PLL_RST;
          timeout_next = sat_inc(timeout_cnt);
        end else begin
          tmo_next = tmo_cnt + CNT_ONE;
          if (!lock_s)                        state_next = ST_WAIT_LOCK;
          else if (phase_cnt == STABLE_LAST)  state_next = ST_DIV_RELEASE;
        end
      end
      ST_DIV_RELEASE: begin
        phase_run = 1'b1;
        if (!lock_s) begin
          state_next  = ST_PLL_RST;
          relock_next = sat_inc(relock_cnt);
        end else if (phase_cnt == DIV_LAST) begin
          state_next = ST_SER_RELEASE;
        end
      end
      ST_SER_RELEASE: begin
        phase_run = 1'b1;
        if (!lock_s) begin
          state_next  = ST_PLL_RST;
          relock_next = sat_inc(relock_cnt);
        end else if (phase_cnt == SER_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_next  = ST_PLL_RST;
          relock_next = sat_inc(relock_cnt);
        end
      end
      default: state_next = ST_PLL_RST;
    endcase

    // Soft restart overrides everything and suppresses status counting.
    if (restart) begin
      state_next   = ST_PLL_RST;
      timeout_next = timeout_cnt;
      relock_next  = relock_cnt;
    end

    // Phase counter restarts on every entry (including restart within
    // PLL_RST); it only advances in the timed states.
    if (restart || (state_next != state)) phase_next = '0;
    else if (phase_run)                   phase_next = phase_cnt + CNT_ONE;
    else                                  phase_next = phase_cnt;

    // Outputs follow the state being entered so they change on the same
    // edge as the state register; teardown is therefore a single edge.
    case (state_next)
      ST_PLL_RST:     outs_next = 5'b10100;
      ST_WAIT_LOCK:   outs_next = 5'b00100;
      ST_LOCK_STABLE: outs_next = 5'b00100;
      ST_DIV_RELEASE: outs_next = 5'b01100;
      ST_SER_RELEASE: outs_next = 5'b01000;
      ST_RUN:         outs_next = 5'b01011;
      default:        outs_next = 5'b10100;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_clk_rst_seq
// Purpose  : Directed self-checking bench for hdmi_clk_rst_seq using short
//            timing parameters (PLL_RST=4, LOCK_STABLE=8, TIMEOUT=32,
//            DIV_SETTLE=4, SER_SETTLE=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_hdmi_clk_rst_seq;

  localparam logic [4:0] O_RST  = 5'b10100;
  localparam logic [4:0] O_WAIT = 5'b00100;
  localparam logic [4:0] O_DIV  = 5'b01100;
  localparam logic [4:0] O_SER  = 5'b01000;
  localparam logic [4:0] O_RUN  = 5'b01011;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       clkdiv_resetn;
  logic       oser_reset;
  logic       video_resetn;
  logic       ready;
  logic [7:0] timeout_cnt;
  logic [7:0] relock_cnt;
  logic [4:0] outs;
  logic       inv_ok;

  int tests = 0;
  int fails = 0;

  hdmi_clk_rst_seq #(
    .PLL_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT      (32),
    .DIV_SETTLE_CYCLES (4),
    .SER_SETTLE_CYCLES (4),
    .CNT_W             (17)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .restart      (restart),
    .pll_reset    (pll_reset),
    .clkdiv_resetn(clkdiv_resetn),
    .oser_reset   (oser_reset),
    .video_resetn (video_resetn),
    .ready        (ready),
    .timeout_cnt  (timeout_cnt),
    .relock_cnt   (relock_cnt)
  );

  assign outs   = {pll_reset, clkdiv_resetn, oser_reset, video_resetn, ready};
  assign inv_ok = (!ready || video_resetn) && (!video_resetn || !oser_reset) &&
                  (oser_reset || clkdiv_resetn) && (!clkdiv_resetn || !pll_reset);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two reset edges, then release; edge counts in tests start after this.
  task automatic do_reset();
    resetn  = 1'b0;
    restart = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pll_lock = 1'b0; restart = 1'b0;
    step(2);
    tests++; if (outs !== O_RST) begin fails++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
    tests++; if (timeout_cnt !== 8'd0) begin fails++; $display("FAIL reset_timeout got=%0d exp=0", timeout_cnt); end
    tests++; if (relock_cnt !== 8'd0) begin fails++; $display("FAIL reset_relock got=%0d exp=0", relock_cnt); end
  endtask

  // Lock rises after edge 10: sync at 11/12, LOCK_STABLE at 13,
  // DIV at 21, SER at 25, RUN at 29.
  task automatic test_bringup();
    logic [4:0] exp;
    pll_lock = 1'b0;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      step(1);
      if (e <= 3)       exp = O_RST;
      else if (e <= 20) exp = O_WAIT;
      else if (e <= 24) exp = O_DIV;
      else if (e <= 28) exp = O_SER;
      else              exp = O_RUN;
      tests++; if (outs !== exp) begin fails++; $display("FAIL bringup_e%0d got=%b exp=%b", e, outs, exp); end
      tests++; if (inv_ok !== 1'b1) begin fails++; $display("FAIL bringup_inv_e%0d got=%b exp=1", e, outs); end
      if (e == 10) pll_lock = 1'b1;
    end
  endtask

  // No lock: 4 cycles PLL_RST + 32 cycles waiting = 36-cycle period.
  task automatic test_timeout();
    logic       exp_pr;
    logic [7:0] exp_to;
    pll_lock = 1'b0;
    do_reset();
    for (int e = 1; e <= 110; e++) begin
      step(1);
      exp_pr = ((e % 36) < 4);
      exp_to = 8'(e / 36);
      tests++; if (pll_reset !== exp_pr) begin fails++; $display("FAIL timeout_pll_reset_e%0d got=%b exp=%b", e, pll_reset, exp_pr); end
      tests++; if (timeout_cnt !== exp_to) begin fails++; $display("FAIL timeout_cnt_e%0d got=%0d exp=%0d", e, timeout_cnt, exp_to); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL timeout_ready_e%0d got=%b exp=0", e, ready); end
    end
  endtask

  task automatic test_timeout_sat();
    pll_lock = 1'b0;
    do_reset();
    step(36 * 254);
    tests++; if (timeout_cnt !== 8'd254) begin fails++; $display("FAIL sat_254 got=%0d exp=254", timeout_cnt); end
    step(36);
    tests++; if (timeout_cnt !== 8'd255) begin fails++; $display("FAIL sat_255 got=%0d exp=255", timeout_cnt); end
    step(36 * 46);
    tests++; if (timeout_cnt !== 8'd255) begin fails++; $display("FAIL sat_hold got=%0d exp=255", timeout_cnt); end
  endtask

  // Lock held from release: LOCK_STABLE at 5. One-cycle low on lock_s seen
  // at edge 11 -> WAIT, LOCK_STABLE again at 12, DIV 20, RUN 28.
  task automatic test_glitch();
    pll_lock = 1'b1;
    do_reset();
    step(8);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(10);
    tests++; if (clkdiv_resetn !== 1'b0) begin fails++; $display("FAIL glitch_div_e19 got=%b exp=0", clkdiv_resetn); end
    step(1);
    tests++; if (clkdiv_resetn !== 1'b1) begin fails++; $display("FAIL glitch_div_e20 got=%b exp=1", clkdiv_resetn); end
    step(7);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL glitch_ready_e27 got=%b exp=0", ready); end
    step(1);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL glitch_ready_e28 got=%b exp=1", ready); end
  endtask

  // RUN at 21; lock drops after 22 -> PLL_RST at 25; relock -> RUN at 46.
  task automatic test_relock();
    pll_lock = 1'b1;
    do_reset();
    step(22);
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL relock_run got=%b exp=%b", outs, O_RUN); end
    pll_lock = 1'b0;
    step(2);
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL relock_sync_delay got=%b exp=%b", outs, O_RUN); end
    step(1);
    tests++; if (outs !== O_RST) begin fails++; $display("FAIL relock_teardown got=%b exp=%b", outs, O_RST); end
    tests++; if (relock_cnt !== 8'd1) begin fails++; $display("FAIL relock_cnt got=%0d exp=1", relock_cnt); end
    pll_lock = 1'b1;
    step(20);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL relock_ready_early got=%b exp=0", ready); end
    step(1);
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL relock_rerun got=%b exp=%b", outs, O_RUN); end
    tests++; if (relock_cnt !== 8'd1) begin fails++; $display("FAIL relock_cnt_hold got=%0d exp=1", relock_cnt); end
  endtask

  // Continues in RUN from test_relock (relock_cnt=1).
  task automatic test_restart();
    pll_lock = 1'b0;
    step(2);
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL restart_pre got=%b exp=%b", outs, O_RUN); end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    tests++; if (outs !== O_RST) begin fails++; $display("FAIL restart_outs got=%b exp=%b", outs, O_RST); end
    tests++; if (relock_cnt !== 8'd1) begin fails++; $display("FAIL restart_relock got=%0d exp=1", relock_cnt); end
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(3);
    tests++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL restart_hold got=%b exp=1", pll_reset); end
    step(1);
    tests++; if (pll_reset !== 1'b0) begin fails++; $display("FAIL restart_release got=%b exp=0", pll_reset); end
  endtask

  // Build relock_cnt=1, reach SER_RELEASE (42..45), then pulse resetn.
  task automatic test_reset_mid();
    pll_lock = 1'b1;
    do_reset();
    step(22);
    pll_lock = 1'b0;
    step(3);
    pll_lock = 1'b1;
    step(18);
    tests++; if (outs !== O_SER) begin fails++; $display("FAIL mid_ser got=%b exp=%b", outs, O_SER); end
    tests++; if (relock_cnt !== 8'd1) begin fails++; $display("FAIL mid_relock_pre got=%0d exp=1", relock_cnt); end
    resetn = 1'b0;
    step(1);
    tests++; if (outs !== O_RST) begin fails++; $display("FAIL mid_reset_outs got=%b exp=%b", outs, O_RST); end
    tests++; if (relock_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset_relock got=%0d exp=0", relock_cnt); end
    resetn = 1'b1;
    step(20);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_ready_early got=%b exp=0", ready); end
    step(1);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b exp=1", ready); end
  endtask

  initial begin
    resetn   = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_timeout_sat();
    test_glitch();
    test_relock();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
